wb_stage: RTL and testbench

Writeback stage of the five-stage pipelined MIPS CPU. It holds the M/W pipeline register, extends load data by type and byte offset, selects the writeback value, and drives the register-file write port (`we`, `a3`, `wd`, `wpc`). It also exports the W-stage forwarding value and a retired-instruction counter.

---
 rtl/wb_stage.sv | 116 +++++++++++
 tb/tb_wb_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: M/W register, load extension, GRF write port, forwarding and instret; optional WB_TRACE_EN write trace.
// Latency: M inputs captured at a posedge drive outputs right after it; stall holds W, flush (priority) loads a bubble.
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_instr,
  input  logic        m_we,
  input  logic [4:0]  m_a3,
  input  logic [1:0]  m_wdsel,
  input  logic [2:0]  m_ldtype,
  input  logic [1:0]  m_addr_lo,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_rdata,
  input  logic [31:0] m_mdu,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_wpc,
  output logic [31:0] w_instr,
  output logic        fwd_valid,
  output logic [4:0]  fwd_a3,
  output logic [31:0] fwd_wd,
  output logic [31:0] instret
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  a3;
    logic [1:0]  wdsel;
    logic [2:0]  ldtype;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] mdu;
  } wreg_t;

  wreg_t       r_w;
  logic [31:0] r_instret;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  logic [31:0] w_wd;
  logic        w_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w       <= '0;
      r_instret <= '0;
    end else if (flush) begin
      r_w <= '0;
    end else if (!stall) begin
      r_w.valid   <= m_valid;
      r_w.pc      <= m_pc;
      r_w.instr   <= m_instr;
      r_w.we      <= m_we;
      r_w.a3      <= m_a3;
      r_w.wdsel   <= m_wdsel;
      r_w.ldtype  <= m_ldtype;
      r_w.addr_lo <= m_addr_lo;
      r_w.alu     <= m_alu;
      r_w.rdata   <= m_rdata;
      r_w.mdu     <= m_mdu;
      if (m_valid) r_instret <= r_instret + 32'd1;
    end
  end

  // Halfword select ignores addr_lo[0]; unaligned halfwords are not trapped here.
  always_comb begin
    w_byte = r_w.rdata[8*r_w.addr_lo +: 8];
    w_half = r_w.addr_lo[1] ? r_w.rdata[31:16] : r_w.rdata[15:0];
    case (r_w.ldtype)
      3'd1:    w_ld = {{24{w_byte[7]}}, w_byte};
      3'd2:    w_ld = {24'd0, w_byte};
      3'd3:    w_ld = {{16{w_half[15]}}, w_half};
      3'd4:    w_ld = {16'd0, w_half};
      default: w_ld = r_w.rdata;
    endcase
  end

  always_comb begin
    case (r_w.wdsel)
      2'd0:    w_wd = r_w.alu;
      2'd1:    w_wd = w_ld;
      2'd2:    w_wd = r_w.pc + 32'd8;
      default: w_wd = r_w.mdu;
    endcase
  end

  assign w_we      = r_w.valid & r_w.we & (r_w.a3 != 5'd0);
  assign grf_we    = w_we;
  assign grf_a3    = r_w.a3;
  assign grf_wd    = w_wd;
  assign grf_wpc   = r_w.valid ? r_w.pc : RESET_PC;
  assign w_instr   = r_w.instr;
  assign fwd_valid = w_we;
  assign fwd_a3    = r_w.a3;
  assign fwd_wd    = w_wd;
  assign instret   = r_instret;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (reset && grf_we) $display("%d@%h: $%d <= %h", $time, grf_wpc, grf_a3, grf_wd);
  end
`else
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/load/link/MDU writeback, $0 suppression, stall/flush, async reset.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush, m_valid, m_we;
  logic [31:0] m_pc, m_instr, m_alu, m_rdata, m_mdu;
  logic [4:0]  m_a3;
  logic [1:0]  m_wdsel, m_addr_lo;
  logic [2:0]  m_ldtype;
  logic        grf_we, fwd_valid;
  logic [4:0]  grf_a3, fwd_a3;
  logic [31:0] grf_wd, grf_wpc, w_instr, fwd_wd, instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = 32'd0;

  always #5 clk = ~clk;

  wb_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_instr(m_instr), .m_we(m_we), .m_a3(m_a3),
    .m_wdsel(m_wdsel), .m_ldtype(m_ldtype), .m_addr_lo(m_addr_lo),
    .m_alu(m_alu), .m_rdata(m_rdata), .m_mdu(m_mdu),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_wpc(grf_wpc),
    .w_instr(w_instr), .fwd_valid(fwd_valid), .fwd_a3(fwd_a3), .fwd_wd(fwd_wd),
    .instret(instret)
  );

  task automatic drive_m(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic we, input logic [4:0] a3, input logic [1:0] sel,
                         input logic [2:0] ld, input logic [1:0] lo, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [31:0] mdu);
    m_valid = v; m_pc = pc; m_instr = ins; m_we = we; m_a3 = a3; m_wdsel = sel;
    m_ldtype = ld; m_addr_lo = lo; m_alu = alu; m_rdata = rd; m_mdu = mdu;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({grf_we, grf_a3, grf_wd, grf_wpc, w_instr, fwd_valid, fwd_a3, fwd_wd, instret} !==
        {1'b0, 5'd0, 32'd0, 32'h3000, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0}) begin
      $display("FAIL reset_outputs: we=%b a3=%0d wd=%h wpc=%h instr=%h fv=%b fa3=%0d fwd=%h instret=%0d",
               grf_we, grf_a3, grf_wd, grf_wpc, w_instr, fwd_valid, fwd_a3, fwd_wd, instret);
      errors++;
    end
  endtask

  task automatic test_alu();
    drive_m(1, 32'h3004, 32'h0109_4021, 1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h5555_AAAA);
    step(); exp_instret++;
    checks++;
    if ({grf_we, grf_a3, grf_wd, grf_wpc} !== {1'b1, 5'd8, 32'h1234_5678, 32'h3004}) begin
      $display("FAIL alu_wb: got we=%b a3=%0d wd=%h wpc=%h exp 1/8/12345678/00003004", grf_we, grf_a3, grf_wd, grf_wpc);
      errors++;
    end
    checks++;
    if ({fwd_valid, fwd_a3, fwd_wd, w_instr} !== {1'b1, 5'd8, 32'h1234_5678, 32'h0109_4021}) begin
      $display("FAIL alu_fwd: got fv=%b fa3=%0d fwd=%h instr=%h", fwd_valid, fwd_a3, fwd_wd, w_instr);
      errors++;
    end
    checks++;
    if (instret !== 32'd1) begin
      $display("FAIL alu_instret: got %0d exp 1", instret); errors++;
    end
  endtask

  task automatic test_load();
    logic [2:0]  ld [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd3};
    logic [1:0]  lo [7] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3};
    logic [31:0] ex [7] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01,
                            32'h80FF_7F01, 32'h0000_007F, 32'hFFFF_80FF};
    for (int i = 0; i < 7; i++) begin
      drive_m(1, 32'h3100 + 32'(4*i), 32'h8C00_0000, 1, 5'd9, 2'd1, ld[i], lo[i], 32'h1111_1111, 32'h80FF_7F01, 32'h2222_2222);
      step(); exp_instret++;
      checks++;
      if (grf_wd !== ex[i] || grf_we !== 1'b1) begin
        $display("FAIL load_ext[%0d]: got wd=%h we=%b exp wd=%h we=1", i, grf_wd, grf_we, ex[i]);
        errors++;
      end
    end
  endtask

  task automatic test_link_mdu();
    drive_m(1, 32'h3008, 32'h0C00_0000, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    step(); exp_instret++;
    checks++;
    if (grf_wd !== 32'h3010) begin $display("FAIL link_pc8: got %h exp 00003010", grf_wd); errors++; end
    drive_m(1, 32'hFFFF_FFFC, 32'h0C00_0001, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    step(); exp_instret++;
    checks++;
    if (grf_wd !== 32'h0000_0004 || grf_wpc !== 32'hFFFF_FFFC) begin
      $display("FAIL link_wrap: got wd=%h wpc=%h exp 00000004/fffffffc", grf_wd, grf_wpc); errors++;
    end
    drive_m(1, 32'h3200, 32'h0000_4010, 1, 5'd3, 2'd3, 3'd0, 2'd0, 32'h0, 32'h0, 32'hCAFE_F00D);
    step(); exp_instret++;
    checks++;
    if (grf_wd !== 32'hCAFE_F00D) begin $display("FAIL mdu_wb: got %h exp cafef00d", grf_wd); errors++; end
  endtask

  task automatic test_zero_reg();
    drive_m(1, 32'h3300, 32'h0000_0020, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h7777_7777, 32'h0, 32'h0);
    step(); exp_instret++;
    checks++;
    if (grf_we !== 1'b0 || fwd_valid !== 1'b0) begin
      $display("FAIL zero_reg_we: got we=%b fv=%b exp 0/0", grf_we, fwd_valid); errors++;
    end
    checks++;
    if (instret !== exp_instret) begin
      $display("FAIL zero_reg_instret: got %0d exp %0d", instret, exp_instret); errors++;
    end
    drive_m(0, 32'h3304, 32'h0, 1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h4444_4444, 32'h0, 32'h0);
    step();
    checks++;
    if (grf_we !== 1'b0 || grf_wpc !== 32'h3000 || instret !== exp_instret) begin
      $display("FAIL invalid_entry: got we=%b wpc=%h instret=%0d exp 0/00003000/%0d", grf_we, grf_wpc, instret, exp_instret);
      errors++;
    end
  endtask

  task automatic test_stall_flush();
    drive_m(1, 32'h3400, 32'hAAAA_0001, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'hA5A5_0001, 32'h0, 32'h0);
    step(); exp_instret++;
    drive_m(1, 32'h3404, 32'hBBBB_0002, 1, 5'd13, 2'd0, 3'd0, 2'd0, 32'hB5B5_0002, 32'h0, 32'h0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({grf_we, grf_a3, grf_wd, grf_wpc, instret} !== {1'b1, 5'd12, 32'hA5A5_0001, 32'h3400, exp_instret}) begin
        $display("FAIL stall_hold[%0d]: got a3=%0d wd=%h wpc=%h instret=%0d exp 12/a5a50001/00003400/%0d",
                 k, grf_a3, grf_wd, grf_wpc, instret, exp_instret);
        errors++;
      end
    end
    flush = 1'b1;
    step();
    checks++;
    if ({grf_we, grf_a3, grf_wd, grf_wpc, w_instr, fwd_valid, instret} !==
        {1'b0, 5'd0, 32'd0, 32'h3000, 32'd0, 1'b0, exp_instret}) begin
      $display("FAIL flush_bubble: got we=%b a3=%0d wd=%h wpc=%h instr=%h fv=%b instret=%0d exp instret %0d",
               grf_we, grf_a3, grf_wd, grf_wpc, w_instr, fwd_valid, instret, exp_instret);
      errors++;
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_m(1, 32'h3500, 32'hCCCC_0003, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h0BAD_F00D, 32'h0, 32'h0);
    step();
    #2 reset = 1'b0;
    #1;
    exp_instret = 32'd0;
    test_reset();
    @(negedge clk);
    checks++;
    if (instret !== 32'd0 || grf_we !== 1'b0) begin
      $display("FAIL reset_held: got instret=%0d we=%b exp 0/0", instret, grf_we); errors++;
    end
    #2 reset = 1'b1;
    step(); exp_instret++;
    checks++;
    if (grf_wd !== 32'h0BAD_F00D || instret !== 32'd1) begin
      $display("FAIL post_reset_capture: got wd=%h instret=%0d exp 0badf00d/1", grf_wd, instret); errors++;
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_m(0, 32'h0, 32'h0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    #3;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_alu();
    test_load();
    test_link_mdu();
    test_zero_reg();
    test_stall_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
